// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared descriptor type and default constants for sprite_index_pipe
package sprite_pkg;
  localparam int NUM_CH_DEF  = 4;
  localparam int VIEW_X0_DEF = 203;
  localparam int VIEW_Y0_DEF = 152;
  localparam int VIEW_W_DEF  = 233;
  localparam int VIEW_H_DEF  = 176;
  localparam int IDX_W_DEF   = 18;
  localparam int DIM_W       = 9;
  localparam int COORD_W     = 10;
  localparam int IDX_INT_W   = 20;

  typedef struct packed {
    logic               en;
    logic               dir;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [3:0]         frame_x;
    logic [3:0]         frame_y;
    logic [DIM_W-1:0]   img_w;
    logic [DIM_W-1:0]   img_h;
    logic [DIM_W-1:0]   sheet_w;
  } sprite_desc_t;
endpackage

// File: rtl/sprite_hit_calc.sv
// rtl/sprite_hit_calc.sv - per-channel coverage test with frame-local row and column
module sprite_hit_calc
  import sprite_pkg::*;
(
  input  logic                    en,
  input  logic                    in_view,
  input  logic signed [COORD_W:0] rx,
  input  logic signed [COORD_W:0] ry,
  input  logic [COORD_W-1:0]      pos_x,
  input  logic [COORD_W-1:0]      pos_y,
  input  logic [DIM_W-1:0]        img_w,
  input  logic [DIM_W-1:0]        img_h,
  output logic                    hit,
  output logic [DIM_W-1:0]        col,
  output logic [DIM_W-1:0]        row
);
  localparam int EW = COORD_W + 3;

  logic signed [EW-1:0] rx_e, ry_e, lx, rx_end, top, bot;

  // Widened signed so a sprite hanging off the left edge gives a negative lx.
  assign rx_e   = {{2{rx[COORD_W]}}, rx};
  assign ry_e   = {{2{ry[COORD_W]}}, ry};
  assign lx     = $signed({{(EW-COORD_W){1'b0}}, pos_x})
                - $signed({{(EW-DIM_W+1){1'b0}}, img_w[DIM_W-1:1]});
  assign rx_end = lx + $signed({{(EW-DIM_W){1'b0}}, img_w});
  assign top    = $signed({{(EW-COORD_W){1'b0}}, pos_y});
  assign bot    = top + $signed({{(EW-DIM_W){1'b0}}, img_h});

  assign hit = en & in_view & (rx_e >= lx) & (rx_e < rx_end) & (ry_e >= top) & (ry_e < bot);
  assign col = rx_e[DIM_W-1:0] - lx[DIM_W-1:0];
  assign row = ry_e[DIM_W-1:0] - top[DIM_W-1:0];
endmodule

// File: rtl/sprite_index_pipe.sv
// rtl/sprite_index_pipe.sv - 3-stage multi-channel sprite ROM index generator
// SPRITE_MIRROR_EN enables stored facing and horizontal mirroring.
module sprite_index_pipe
  import sprite_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int VIEW_X0 = VIEW_X0_DEF,
  parameter int VIEW_Y0 = VIEW_Y0_DEF,
  parameter int VIEW_W  = VIEW_W_DEF,
  parameter int VIEW_H  = VIEW_H_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic               cfg_en,
  input  logic               cfg_dir,
  input  logic [COORD_W-1:0] cfg_pos_x,
  input  logic [COORD_W-1:0] cfg_pos_y,
  input  logic [3:0]         cfg_frame_x,
  input  logic [3:0]         cfg_frame_y,
  input  logic [DIM_W-1:0]   cfg_img_w,
  input  logic [DIM_W-1:0]   cfg_img_h,
  input  logic [DIM_W-1:0]   cfg_sheet_w,
  output logic               out_valid,
  output logic               out_in_view,
  output logic               out_hit,
  output logic [CH_W-1:0]    out_ch,
  output logic [IDX_W-1:0]   out_index
);
  localparam int SW = COORD_W + 1;
  localparam logic signed [SW-1:0] VX0 = SW'(VIEW_X0);
  localparam logic signed [SW-1:0] VY0 = SW'(VIEW_Y0);
  localparam logic signed [SW-1:0] VW  = SW'(VIEW_W);
  localparam logic signed [SW-1:0] VH  = SW'(VIEW_H);

  sprite_desc_t shd [NUM_CH];
  sprite_desc_t act [NUM_CH];
  sprite_desc_t wr_desc;
  logic         ready_q;

  assign cfg_ready = ready_q & ~frame_start;

  always_comb begin
    wr_desc         = '0;
    wr_desc.en      = cfg_en;
`ifdef SPRITE_MIRROR_EN
    wr_desc.dir     = cfg_dir;
`endif
    wr_desc.pos_x   = cfg_pos_x;
    wr_desc.pos_y   = cfg_pos_y;
    wr_desc.frame_x = cfg_frame_x;
    wr_desc.frame_y = cfg_frame_y;
    wr_desc.img_w   = cfg_img_w;
    wr_desc.img_h   = cfg_img_h;
    wr_desc.sheet_w = cfg_sheet_w;
  end

  // Writes and commits never coincide: cfg_ready is low during frame_start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ready_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shd[i] <= '0;
        act[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      if (cfg_valid && cfg_ready) shd[cfg_ch] <= wr_desc;
      if (frame_start) begin
        for (int i = 0; i < NUM_CH; i++) act[i] <= shd[i];
      end
    end
  end

  logic signed [SW-1:0] rx_c, ry_c, s1_rx, s1_ry;
  logic                 in_view_c, s1_valid, s1_in_view;

  assign rx_c      = $signed({1'b0, DrawX}) - VX0;
  assign ry_c      = $signed({1'b0, DrawY}) - VY0;
  assign in_view_c = !rx_c[SW-1] && (rx_c < VW) && !ry_c[SW-1] && (ry_c < VH);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid   <= 1'b0;
      s1_in_view <= 1'b0;
      s1_rx      <= '0;
      s1_ry      <= '0;
    end else begin
      s1_valid   <= pix_valid;
      s1_in_view <= in_view_c;
      s1_rx      <= rx_c;
      s1_ry      <= ry_c;
    end
  end

  logic [NUM_CH-1:0] hit_v;
  logic [DIM_W-1:0]  col_v [NUM_CH];
  logic [DIM_W-1:0]  row_v [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sprite_hit_calc u_hit (
      .en      (act[g].en),
      .in_view (s1_in_view),
      .rx      (s1_rx),
      .ry      (s1_ry),
      .pos_x   (act[g].pos_x),
      .pos_y   (act[g].pos_y),
      .img_w   (act[g].img_w),
      .img_h   (act[g].img_h),
      .hit     (hit_v[g]),
      .col     (col_v[g]),
      .row     (row_v[g])
    );
  end

  logic             win_hit;
  logic [CH_W-1:0]  win_ch;
  logic [DIM_W-1:0] win_col, win_row, win_iw, win_ih, win_sw;
  logic [3:0]       win_fx, win_fy;
`ifdef SPRITE_MIRROR_EN
  logic             win_dir, s2_dir;
`else
  logic [NUM_CH-1:0] unused_act_dir;
  logic              unused_cfg_dir;
  assign unused_cfg_dir = cfg_dir;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unused
    assign unused_act_dir[g] = act[g].dir;
  end
`endif

  // Descending scan so the lowest-numbered hitting channel is the last to assign.
  always_comb begin
    win_hit = 1'b0;
    win_ch  = '0;
    win_col = '0;
    win_row = '0;
    win_iw  = '0;
    win_ih  = '0;
    win_sw  = '0;
    win_fx  = '0;
    win_fy  = '0;
`ifdef SPRITE_MIRROR_EN
    win_dir = 1'b0;
`endif
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        win_hit = 1'b1;
        win_ch  = CH_W'(i);
        win_col = col_v[i];
        win_row = row_v[i];
        win_iw  = act[i].img_w;
        win_ih  = act[i].img_h;
        win_sw  = act[i].sheet_w;
        win_fx  = act[i].frame_x;
        win_fy  = act[i].frame_y;
`ifdef SPRITE_MIRROR_EN
        win_dir = act[i].dir;
`endif
      end
    end
  end

  logic             s2_valid, s2_in_view, s2_hit;
  logic [CH_W-1:0]  s2_ch;
  logic [DIM_W-1:0] s2_col, s2_row, s2_iw, s2_ih, s2_sw;
  logic [3:0]       s2_fx, s2_fy;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid   <= 1'b0;
      s2_in_view <= 1'b0;
      s2_hit     <= 1'b0;
      s2_ch      <= '0;
      s2_col     <= '0;
      s2_row     <= '0;
      s2_iw      <= '0;
      s2_ih      <= '0;
      s2_sw      <= '0;
      s2_fx      <= '0;
      s2_fy      <= '0;
`ifdef SPRITE_MIRROR_EN
      s2_dir     <= 1'b0;
`endif
    end else begin
      s2_valid   <= s1_valid;
      s2_in_view <= s1_in_view;
      s2_hit     <= win_hit;
      s2_ch      <= win_ch;
      s2_col     <= win_col;
      s2_row     <= win_row;
      s2_iw      <= win_iw;
      s2_ih      <= win_ih;
      s2_sw      <= win_sw;
      s2_fx      <= win_fx;
      s2_fy      <= win_fy;
`ifdef SPRITE_MIRROR_EN
      s2_dir     <= win_dir;
`endif
    end
  end

  logic [DIM_W-1:0]     eff_col;
  logic [IDX_INT_W-1:0] row_term, idx_full;
  logic                 s2_take;

`ifdef SPRITE_MIRROR_EN
  assign eff_col = s2_dir ? (s2_iw - DIM_W'(1) - s2_col) : s2_col;
`else
  assign eff_col = s2_col;
`endif
  assign row_term = IDX_INT_W'(s2_fy) * IDX_INT_W'(s2_ih) + IDX_INT_W'(s2_row);
  assign idx_full = row_term * IDX_INT_W'(s2_sw)
                  + IDX_INT_W'(s2_fx) * IDX_INT_W'(s2_iw) + IDX_INT_W'(eff_col);
  assign s2_take  = s2_valid & s2_hit;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid   <= 1'b0;
      out_in_view <= 1'b0;
      out_hit     <= 1'b0;
      out_ch      <= '0;
      out_index   <= '0;
    end else begin
      out_valid   <= s2_valid;
      out_in_view <= s2_valid & s2_in_view;
      out_hit     <= s2_take;
      out_ch      <= s2_take ? s2_ch : '0;
      out_index   <= s2_take ? IDX_W'(idx_full) : '0;
    end
  end
endmodule

// File: tb/tb_sprite_index_pipe.sv
// tb/tb_sprite_index_pipe.sv - directed and randomized checks of sprite_index_pipe against a reference model
// Expected mirror behaviour follows SPRITE_MIRROR_EN.
module tb_sprite_index_pipe;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start, pix_valid;
  logic [9:0]  DrawX, DrawY;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_ch;
  logic        cfg_en, cfg_dir;
  logic [9:0]  cfg_pos_x, cfg_pos_y;
  logic [3:0]  cfg_frame_x, cfg_frame_y;
  logic [8:0]  cfg_img_w, cfg_img_h, cfg_sheet_w;
  logic        out_valid, out_in_view, out_hit;
  logic [1:0]  out_ch;
  logic [17:0] out_index;

`ifdef SPRITE_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  typedef struct {int en, dir, px, py, fx, fy, iw, ih, sw;} mdesc_t;
  typedef struct {int v, iv, hit, ch, idx;} mexp_t;

  mdesc_t m_shd [4];
  mdesc_t m_act [4];
  mexp_t  pipe_q [$];
  int     m_rdy;
  int     n_cmp, n_bad;

  always #5 Clk = ~Clk;

  sprite_index_pipe dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_dir(cfg_dir),
    .cfg_pos_x(cfg_pos_x), .cfg_pos_y(cfg_pos_y),
    .cfg_frame_x(cfg_frame_x), .cfg_frame_y(cfg_frame_y),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h), .cfg_sheet_w(cfg_sheet_w),
    .out_valid(out_valid), .out_in_view(out_in_view), .out_hit(out_hit),
    .out_ch(out_ch), .out_index(out_index)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Screen-space rules: viewport test, sprite box around its centre, first enabled channel wins.
  function automatic mexp_t model_pix(input int pv, input int dx, input int dy);
    mexp_t e = '{default: 0};
    int rx, ry, lx, col, row, c;
    if (pv == 0) return e;
    e.v = 1;
    rx = dx - 203;
    ry = dy - 152;
    e.iv = (rx >= 0 && rx < 233 && ry >= 0 && ry < 176) ? 1 : 0;
    if (e.iv == 0) return e;
    for (int i = 0; i < 4; i++) begin
      lx = m_act[i].px - m_act[i].iw / 2;
      if (e.hit == 0 && m_act[i].en != 0 && rx >= lx && rx < lx + m_act[i].iw &&
          ry >= m_act[i].py && ry < m_act[i].py + m_act[i].ih) begin
        e.hit = 1;
        e.ch  = i;
        col   = rx - lx;
        row   = ry - m_act[i].py;
        c     = (MIRROR && m_act[i].dir != 0) ? m_act[i].iw - 1 - col : col;
        e.idx = ((m_act[i].fy * m_act[i].ih + row) * m_act[i].sw + m_act[i].fx * m_act[i].iw + c)
                % (1 << 18);
      end
    end
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      m_shd[i] = '{default: 0};
      m_act[i] = '{default: 0};
    end
    pipe_q.delete();
    m_rdy = 0;
  endtask

  // One clock: drive at edge+1, check ready, advance, check the pixel from three cycles back.
  task automatic cycle(input int pv, input int dx, input int dy, input int fs);
    mexp_t e, got;
    int    exp_rdy;
    pix_valid   = (pv != 0);
    DrawX       = 10'(dx);
    DrawY       = 10'(dy);
    frame_start = (fs != 0);
    exp_rdy     = (m_rdy != 0 && fs == 0) ? 1 : 0;
    #1;
    check("cfg_ready", cfg_ready, exp_rdy);
    if (fs != 0) for (int i = 0; i < 4; i++) m_act[i] = m_shd[i];
    e = model_pix(pv, dx, dy);
    if (cfg_valid && exp_rdy != 0)
      m_shd[cfg_ch] = '{int'(cfg_en), int'(cfg_dir), int'(cfg_pos_x), int'(cfg_pos_y),
                        int'(cfg_frame_x), int'(cfg_frame_y), int'(cfg_img_w),
                        int'(cfg_img_h), int'(cfg_sheet_w)};
    @(posedge Clk);
    #1;
    m_rdy = 1;
    pipe_q.push_back(e);
    if (pipe_q.size() == 3) begin
      got = pipe_q.pop_front();
      check("out_valid", out_valid, got.v);
      check("out_in_view", out_in_view, got.iv);
      check("out_hit", out_hit, got.hit);
      check("out_ch", out_ch, got.ch);
      check("out_index", out_index, got.idx);
    end else begin
      check("fill_valid", out_valid, 0);
      check("fill_hit", out_hit, 0);
      check("fill_index", out_index, 0);
    end
  endtask

  task automatic set_cfg(input int ch, input int en, input int dir, input int px, input int py,
                         input int fx, input int fy, input int iw, input int ih, input int sw);
    cfg_valid   = 1'b1;
    cfg_ch      = 2'(ch);
    cfg_en      = (en != 0);
    cfg_dir     = (dir != 0);
    cfg_pos_x   = 10'(px);
    cfg_pos_y   = 10'(py);
    cfg_frame_x = 4'(fx);
    cfg_frame_y = 4'(fy);
    cfg_img_w   = 9'(iw);
    cfg_img_h   = 9'(ih);
    cfg_sheet_w = 9'(sw);
  endtask

  task automatic write_desc(input int ch, input int en, input int dir, input int px, input int py,
                            input int fx, input int fy, input int iw, input int ih, input int sw);
    set_cfg(ch, en, dir, px, py, fx, fy, iw, ih, sw);
    cycle(0, 0, 0, 0);
    cfg_valid = 1'b0;
  endtask

  task automatic probe(input int dx, input int dy);
    cycle(1, dx, dy, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_model();
    Reset_n = 1'b0;
    frame_start = 1'b0; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
    cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cfg_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_hit", out_hit, 0);
    check("rst_index", out_index, 0);
    check("rst_ready", cfg_ready, 0);
    Reset_n = 1'b1;
    cycle(0, 0, 0, 0);

    write_desc(0, 1, 0, 50, 20, 2, 1, 28, 26, 280);
    cycle(0, 0, 0, 1);
    probe(261, 180);
    check("basic_hit", out_hit, 1);
    check("basic_ch", out_ch, 0);
    check("basic_index", out_index, 9598);

    write_desc(0, 1, 1, 50, 20, 2, 1, 28, 26, 280);
    cycle(0, 0, 0, 1);
    probe(261, 180);
    check("mirror_index", out_index, MIRROR ? 9581 : 9598);

    write_desc(0, 0, 0, 50, 20, 2, 1, 28, 26, 280);
    write_desc(1, 1, 0, 50, 20, 2, 1, 28, 26, 280);
    write_desc(2, 1, 0, 50, 20, 0, 0, 28, 26, 280);
    cycle(0, 0, 0, 1);
    probe(261, 180);
    check("prio_ch1", out_ch, 1);
    check("prio_idx1", out_index, 9598);
    write_desc(1, 0, 0, 50, 20, 2, 1, 28, 26, 280);
    cycle(0, 0, 0, 1);
    probe(261, 180);
    check("prio_ch2", out_ch, 2);
    check("prio_idx2", out_index, 2262);

    probe(202, 180);
    check("edge_left_view", out_in_view, 0);
    check("edge_left_index", out_index, 0);
    write_desc(2, 0, 0, 50, 20, 0, 0, 28, 26, 280);
    write_desc(0, 1, 0, 5, 20, 2, 1, 28, 26, 280);
    cycle(0, 0, 0, 1);
    probe(203, 180);
    check("straddle_hit", out_hit, 1);
    check("straddle_index", out_index, 9585);
    probe(221, 180);
    check("last_col_index", out_index, 9603);
    probe(222, 180);
    check("past_right_hit", out_hit, 0);
    check("past_right_view", out_in_view, 1);

    write_desc(3, 1, 0, 100, 100, 0, 0, 10, 10, 10);
    write_desc(3, 1, 0, 120, 100, 1, 0, 10, 10, 10);
    cycle(0, 0, 0, 1);
    probe(323, 252);
    check("last_write_ch", out_ch, 3);
    check("last_write_index", out_index, 15);

    set_cfg(0, 1, 0, 100, 20, 2, 1, 28, 26, 280);
    cycle(1, 221, 180, 1);
    cycle(1, 221, 180, 0);
    cfg_valid = 1'b0;
    repeat (4) cycle(1, 221, 180, 0);
    cycle(1, 221, 180, 1);
    repeat (4) cycle(1, 221, 180, 0);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0)
        set_cfg($urandom_range(0, 3), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 240),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 180),
                $urandom_range(0, 15), $urandom_range(0, 15),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 64),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 64),
                $urandom_range(0, 511));
      else
        cfg_valid = 1'b0;
      if ($urandom_range(0, 15) == 0)
        cycle(($urandom_range(0, 7) != 0), $urandom_range(0, 1023), $urandom_range(0, 1023),
              ($urandom_range(0, 15) == 0));
      else
        cycle(($urandom_range(0, 7) != 0), $urandom_range(190, 450), $urandom_range(140, 340),
              ($urandom_range(0, 15) == 0));
    end
    cfg_valid = 1'b0;

    cycle(1, 261, 180, 0);
    cycle(1, 262, 181, 0);
    Reset_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_view", out_in_view, 0);
    check("midrst_hit", out_hit, 0);
    check("midrst_ch", out_ch, 0);
    check("midrst_index", out_index, 0);
    check("midrst_ready", cfg_ready, 0);
    clear_model();
    pix_valid = 1'b0;
    frame_start = 1'b0;
    @(posedge Clk);
    #1;
    check("midrst_hold_valid", out_valid, 0);
    Reset_n = 1'b1;
    repeat (3) cycle(0, 0, 0, 0);
    repeat (4) cycle(1, 261, 180, 0);
    cycle(0, 0, 0, 1);
    repeat (3) cycle(1, 261, 180, 0);
    write_desc(0, 1, 0, 50, 20, 2, 1, 28, 26, 280);
    cycle(0, 0, 0, 1);
    probe(261, 180);
    check("post_rst_index", out_index, 9598);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
